// File: rtl/seg7_pkg.sv
// Shared glyph codes and scan FSM encoding for the seg7 multiplexed display driver.
// Codes are active-low with dp off: bit7 = dp, bits6:0 = g..a.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [6:0] GLYPH_DARK = 7'h7F;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational nibble-to-segment decoder (active-low g..a).
// SEG7_HEX_EN enables A-F for values 10-15; otherwise they decode as 0.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_0[6:0];
        case (nibble)
            4'h0: glyph = GLYPH_0[6:0];
            4'h1: glyph = GLYPH_1[6:0];
            4'h2: glyph = GLYPH_2[6:0];
            4'h3: glyph = GLYPH_3[6:0];
            4'h4: glyph = GLYPH_4[6:0];
            4'h5: glyph = GLYPH_5[6:0];
            4'h6: glyph = GLYPH_6[6:0];
            4'h7: glyph = GLYPH_7[6:0];
            4'h8: glyph = GLYPH_8[6:0];
            4'h9: glyph = GLYPH_9[6:0];
`ifdef SEG7_HEX_EN
            4'hA: glyph = GLYPH_A[6:0];
            4'hB: glyph = GLYPH_B[6:0];
            4'hC: glyph = GLYPH_C[6:0];
            4'hD: glyph = GLYPH_D[6:0];
            4'hE: glyph = GLYPH_E[6:0];
            4'hF: glyph = GLYPH_F[6:0];
`else
            default: glyph = GLYPH_0[6:0];
`endif
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous double buffering,
// anti-ghost blanking and leading-zero suppression. SEG7_HEX_EN selects hex glyphs.
//
// state    | meaning
// ST_BLANK | slot counter below BLANK_CYCLES: all anodes off, segments dark
// ST_DRIVE | remainder of slot: anode idx low, segments show active digit idx
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam scan_state_t   ST_START  = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] dig;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic                    lz;
    } frame_t;

    frame_t          cap;
    frame_t          pend;
    frame_t          act;
    logic            pend_vld;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [IW-1:0]   idx;
    scan_state_t     state;

    logic            slot_end;
    logic            frame_end;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [3:0]      cur_nib;
    logic [6:0]      glyph;
    logic            suppress;
    logic [7:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] an_drive;

    always_comb begin
        cap.dig   = digits_in;
        cap.dp    = dp_in;
        cap.blank = blank_in;
        cap.lz    = lz_suppress;
    end

    assign cnt_inc   = cnt + CW'(1);
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // A load on the wrap cycle bypasses pending so the new frame already uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            act      <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (load) begin
                pend <= cap;
            end
            if (frame_end) begin
                if (load) begin
                    act <= cap;
                end else if (pend_vld) begin
                    act <= pend;
                end
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_vld <= 1'b1;
            end
        end
    end

    // zero_from[i]: active digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_from = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (act.dig[4*j +: 4] != 4'h0) begin
                    zero_from[i] = 1'b0;
                end
            end
        end
    end

    assign cur_nib = act.dig[4*idx +: 4];

    seg7_glyph_rom u_glyph_rom (
        .nibble (cur_nib),
        .glyph  (glyph)
    );

    always_comb begin
        suppress = act.lz && (idx != '0) && zero_from[idx];
        if (act.blank[idx]) begin
            seg_nxt = SEG_OFF;
        end else begin
            seg_nxt = {~act.dp[idx], suppress ? GLYPH_DARK : glyph};
        end
        an_drive = ~(AN_ONE << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= ST_START;
            an         <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;

            if (state == ST_DRIVE) begin
                an  <= an_drive;
                seg <= seg_nxt;
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
            end

            if (slot_end) begin
                cnt   <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                state <= ST_START;
            end else begin
                cnt   <= cnt_inc;
                state <= (cnt_inc < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
// Each frame is 32 samples: per slot 2 dark then 6 driven, frame_done on the last sample.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;
    logic        load;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int vectors;
    int miscompares;

    logic [3:0] cap_an  [32];
    logic [7:0] cap_seg [32];
    logic       cap_fd  [32];
    logic [7:0] exp_glyph [4];

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_suppress (lz_suppress),
        .load        (load),
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] exp_an(int k);
        if (k % 8 < 2) return 4'hF;
        return ~(4'b0001 << (k / 8));
    endfunction

    function automatic logic [7:0] exp_seg(int k);
        if (k % 8 < 2) return 8'hFF;
        return exp_glyph[k / 8];
    endfunction

    task automatic sample_frame();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            cap_an[k]  = an;
            cap_seg[k] = seg;
            cap_fd[k]  = frame_done;
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic lz);
        digits_in   = d;
        dp_in       = dp;
        blank_in    = bl;
        lz_suppress = lz;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        digits_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0; lz_suppress = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold an=%b seg=%h fd=%b expected an=1111 seg=ff fd=0", an, seg, frame_done);
        end
        rst_n = 1'b1;
        exp_glyph = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
        sample_frame();
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL reset_frame k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
    endtask

    task automatic test_scan_1234();
        bit ok;
        do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
        wait_frame(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL scan_1234_timeout frame_done=0 expected frame_done=1 within 100 cycles");
        end
        exp_glyph = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        sample_frame();
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL scan_1234 k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
    endtask

    task automatic test_lz_dp();
        bit ok;
        do_load(16'h0007, 4'b0100, 4'b0000, 1'b1);
        wait_frame(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL lz_dp_timeout frame_done=0 expected frame_done=1 within 100 cycles");
        end
        exp_glyph = '{8'hF8, 8'hFF, 8'h7F, 8'hFF};
        sample_frame();
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL lz_dp k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
    endtask

    task automatic test_blank_dp();
        bit ok;
        do_load(16'h1111, 4'b1111, 4'b0010, 1'b0);
        wait_frame(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL blank_dp_timeout frame_done=0 expected frame_done=1 within 100 cycles");
        end
        exp_glyph = '{8'h79, 8'hFF, 8'h79, 8'h79};
        sample_frame();
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL blank_dp k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
    endtask

    // Continues directly from the frame boundary left by test_blank_dp.
    task automatic test_midframe();
        exp_glyph = '{8'h79, 8'hFF, 8'h79, 8'h79};
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            cap_an[k] = an; cap_seg[k] = seg; cap_fd[k] = frame_done;
            if (k == 11) begin
                digits_in = 16'h00AB; dp_in = 4'b0000; blank_in = 4'b0000; lz_suppress = 1'b1;
                load = 1'b1;
            end else if (k == 12) begin
                load = 1'b0;
            end
        end
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL midframe_prior k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
`ifdef SEG7_HEX_EN
        exp_glyph = '{8'h83, 8'h88, 8'hFF, 8'hFF};
`else
        exp_glyph = '{8'hC0, 8'hC0, 8'hFF, 8'hFF};
`endif
        sample_frame();
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL midframe_new k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
    endtask

    // Load strobe lands on the wrap edge; the very next frame must use it.
    task automatic test_back_to_back();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            cap_an[k] = an; cap_seg[k] = seg; cap_fd[k] = frame_done;
            if (k == 30) begin
                digits_in = 16'h9080; dp_in = 4'b0000; blank_in = 4'b0000; lz_suppress = 1'b0;
                load = 1'b1;
            end else if (k == 31) begin
                load = 1'b0;
            end
        end
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL boundary_prior k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
        exp_glyph = '{8'hC0, 8'h80, 8'hC0, 8'h90};
        sample_frame();
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                miscompares++;
                $display("FAIL boundary_new k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
            end
        end
    endtask

    task automatic test_reset_midscan();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                digits_in = 16'h4321; dp_in = 4'b1010; blank_in = 4'b0000; lz_suppress = 1'b0;
                load = 1'b1;
            end else if (k == 6) begin
                load = 1'b0;
            end
        end
        vectors++;
        if (an !== 4'b1011 || seg !== 8'hC0) begin
            miscompares++;
            $display("FAIL digit2_drive an=%b seg=%h expected an=1011 seg=c0", an, seg);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset an=%b seg=%h fd=%b expected an=1111 seg=ff fd=0", an, seg, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_glyph = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
        for (int f = 0; f < 2; f++) begin
            sample_frame();
            for (int k = 0; k < 32; k++) begin
                vectors++;
                if (cap_an[k] !== exp_an(k) || cap_seg[k] !== exp_seg(k) || cap_fd[k] !== (k == 31)) begin
                    miscompares++;
                    $display("FAIL post_reset f=%0d k=%0d an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                             f, k, cap_an[k], cap_seg[k], cap_fd[k], exp_an(k), exp_seg(k), k == 31);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_scan_1234();
        test_lz_dp();
        test_blank_dp();
        test_midframe();
        test_back_to_back();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
